// File: rtl/spi_txq.sv
// Paced transmit queue feeding the OLED SPI byte driver.
// Words are popped one at a time and spaced so each start pulse lands while the driver waits.
module spi_txq #(
  parameter int unsigned AW       = 4,
  parameter int unsigned XFER_GAP = 456,
  parameter int unsigned PWR_GAP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [9:0]  wdata,
  input  logic        clr,
  output logic        spi_start,
  output logic [9:0]  spi_din,
  output logic [31:0] status
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned GMAX  = (XFER_GAP > PWR_GAP) ? XFER_GAP : PWR_GAP;
  localparam int unsigned GW    = ($clog2(GMAX) > 9) ? $clog2(GMAX) : 9;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          start_q, start_d;
  logic [9:0]    din_q, din_d;
  logic [9:0]    mem_q [DEPTH];

  logic          empty, full, busy, pop, push;
  logic [9:0]    head;

  // Next-state logic; the last HOLD cycle may pop so byte pulses are exactly XFER_GAP apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    start_d = 1'b0;
    din_d   = din_q;

    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    busy  = (state_q == S_HOLD);
    head  = mem_q[rp_q];
    pop   = !empty && !clr && ((state_q == S_IDLE) || (gap_q == '0));
    push  = we && !clr && (!full || pop);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (gap_q == '0) begin
          state_d = pop ? S_HOLD : S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      start_d = 1'b1;
      din_d   = head;
      rp_d    = rp_q + AW'(1);
      gap_d   = head[9] ? GW'(PWR_GAP - 1) : GW'(XFER_GAP - 1);
    end

    if (push) begin
      wp_d = wp_q + AW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);

    if (we && full && !pop && !clr) begin
      ovf_d = 1'b1;
    end

    // Flush leaves any running gap countdown alone; the driver transfer cannot be stopped.
    if (clr) begin
      rp_d    = '0;
      wp_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      start_q <= start_d;
      din_q   <= din_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wp_q] <= wdata;
    end
  end

  assign spi_start = start_q;
  assign spi_din   = din_q;
  // An idle, empty queue reads 32'h100 (only the empty flag set).
  assign status    = {20'h0, ovf_q, busy, full, empty, 8'(level_q)};

endmodule

// File: tb/tb_spi_txq.sv
// Randomized and directed bench for spi_txq against a queue/timestamp model.
module tb_spi_txq;

  localparam int unsigned AW       = 4;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned XFER_GAP = 456;
  localparam int unsigned PWR_GAP  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [9:0]  wdata = '0;
  logic        clr = 1'b0;
  logic        spi_start;
  logic [9:0]  spi_din;
  logic [31:0] status;

  spi_txq #(.AW(AW), .XFER_GAP(XFER_GAP), .PWR_GAP(PWR_GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wdata     (wdata),
    .clr       (clr),
    .spi_start (spi_start),
    .spi_din   (spi_din),
    .status    (status)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: queue contents plus the time of the last pulse and the spacing it demands.
  logic [9:0] mq[$];
  bit         m_ovf   = 1'b0;
  bit         m_start = 1'b0;
  logic [9:0] m_din   = '0;
  longint     cyc      = 0;
  longint     last_p   = -1000000;
  longint     last_gap = 0;
  logic [9:0] m_head;
  bit         m_pop, m_full;
  longint     ncyc;
  bit         chk_en = 1'b0;

  longint     pt[$];
  logic [9:0] pd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    ncyc = cyc + 1;
    if (reset) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_start  = 1'b0;
      m_din    = '0;
      last_p   = -1000000;
      last_gap = 0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_pop   = (mq.size() != 0) && !clr && (ncyc >= last_p + last_gap);
      m_start = 1'b0;
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (m_pop) begin
          m_head   = mq.pop_front();
          m_start  = 1'b1;
          m_din    = m_head;
          last_p   = ncyc;
          last_gap = m_head[9] ? longint'(PWR_GAP) : longint'(XFER_GAP);
        end
        if (we) begin
          if (!m_full || m_pop) mq.push_back(wdata);
          else m_ovf = 1'b1;
        end
      end
    end
    cyc = ncyc;
  end

  logic [31:0] exp_st;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_st       = '0;
      exp_st[7:0]  = 8'(mq.size());
      exp_st[8]    = (mq.size() == 0);
      exp_st[9]    = (mq.size() == DEPTH);
      exp_st[10]   = (cyc >= last_p) && (cyc < last_p + last_gap);
      exp_st[11]   = m_ovf;
      check("spi_start", 32'(spi_start), 32'(m_start));
      check("spi_din", 32'(spi_din), 32'(m_din));
      check("status", status, exp_st);
    end
  end

  always @(negedge clk) begin
    if (chk_en && spi_start === 1'b1) begin
      pt.push_back(cyc);
      pd.push_back(spi_din);
    end
  end

  task automatic write_word(input logic [9:0] d);
    we    = 1'b1;
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(status[10] == 1'b0 && status[8] == 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 20000), 32'd1);
  endtask

  initial begin
    int n;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_din", 32'(spi_din), 32'd0);
    check("rst_status", status, 32'h100);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    // Single byte word: 2-edge latency, busy for XFER_GAP cycles
    write_word(10'h1AF);
    check("t1_level", status, 32'h001);
    @(negedge clk);
    check("t1_start", 32'(spi_start), 32'd1);
    check("t1_din", 32'(spi_din), 32'h1AF);
    n = 0;
    while (status[10] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("t1_busy_len", 32'(n), 32'd456);
    check("t1_status_idle", status, 32'h100);

    // Burst of three byte words
    pt.delete(); pd.delete();
    write_word(10'h0AE);
    write_word(10'h081);
    write_word(10'h17F);
    check("t2_level", 32'(status[7:0]), 32'd2);
    wait_idle();
    check("t2_count", 32'(pd.size()), 32'd3);
    if (pd.size() == 3) begin
      check("t2_d0", 32'(pd[0]), 32'h0AE);
      check("t2_d1", 32'(pd[1]), 32'h081);
      check("t2_d2", 32'(pd[2]), 32'h17F);
      check("t2_gap01", 32'(pt[1] - pt[0]), 32'd456);
      check("t2_gap12", 32'(pt[2] - pt[1]), 32'd456);
    end

    // Power word then byte word
    pt.delete(); pd.delete();
    write_word(10'h200);
    write_word(10'h0AF);
    wait_idle();
    check("t3_count", 32'(pd.size()), 32'd2);
    if (pd.size() == 2) begin
      check("t3_d0", 32'(pd[0]), 32'h200);
      check("t3_d1", 32'(pd[1]), 32'h0AF);
      check("t3_gap", 32'(pt[1] - pt[0]), 32'd2);
    end

    // Fill behind HOLD, overflow, then push during a pop
    pt.delete(); pd.delete();
    write_word(10'h011);
    @(negedge clk);
    for (int i = 0; i < 17; i++) write_word(10'h0C0 + 10'(i));
    check("t4_full_ovf", status, 32'hE10);
    n = 0;
    while (cyc != last_p + last_gap - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    write_word(10'h155);
    check("t4_pop_start", 32'(spi_start), 32'd1);
    check("t4_pop_din", 32'(spi_din), 32'h0C0);
    check("t4_still_full", status, 32'hE10);
    wait_idle();
    check("t4_count", 32'(pd.size()), 32'd18);
    if (pd.size() == 18) begin
      check("t4_last_fill", 32'(pd[16]), 32'h0CF);
      check("t4_late_push", 32'(pd[17]), 32'h155);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t4_clr_ovf", status, 32'h100);

    // clr mid-HOLD with five queued
    for (int i = 0; i < 6; i++) write_word(10'h040 + 10'(i));
    check("t5_level5", status, 32'h405);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_after_clr", status, 32'h500);
    pt.delete(); pd.delete();
    wait_idle();
    check("t5_no_pulse", 32'(pd.size()), 32'd0);

    // Reset during HOLD with three queued
    for (int i = 0; i < 4; i++) write_word(10'h060 + 10'(i));
    check("t6_level3", status, 32'h403);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_start", 32'(spi_start), 32'd0);
    check("t6_rst_status", status, 32'h100);
    write_word(10'h0F0);
    @(negedge clk);
    check("t6_start", 32'(spi_start), 32'd1);
    check("t6_din", 32'(spi_din), 32'h0F0);
    wait_idle();

    // Random traffic, mostly power words so the queue both drains and saturates
    for (int i = 0; i < 15000; i++) begin
      we    = ($urandom_range(0, 5) == 0);
      wdata = 10'($urandom);
      if ($urandom_range(0, 7) != 0) wdata[9] = 1'b1;
      clr   = ($urandom_range(0, 399) == 0);
      reset = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    we    = 1'b0;
    clr   = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
